// File: rtl/rom_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rom_bus_ctrl
//  Purpose  : Z80-side access controller for the two 8 KB pROM halves that
//             together hold the 16 KB Spectrum ROM. It decodes CPU memory
//             reads in 0x0000-0x3FFF, latches the ROM word address, and
//             drives the ROM wrappers' ce/oce/iorq/ad inputs. It also holds
//             wait_n low until the registered pROM output is valid on the
//             shared data bus.
//  Ports    : clk            - system clock; all inputs are synchronous to it
//             reset          - asynchronous, active-low reset
//             addr           - CPU address bus
//             mreq_n, rd_n,
//             wr_n, iorq_n   - CPU bus strobes, active-low
//             rom_ad         - ROM word address, shared by both halves
//             rom0_ce        - chip enable, lower half (0x0000-0x1FFF)
//             rom1_ce        - chip enable, upper half (0x2000-0x3FFF)
//             rom_oce        - output-register enable, shared
//             rom_iorq       - active-high I/O flag to the ROM wrappers
//             wait_n         - CPU wait request, active-low
//             rom_wr_ignored - one-cycle pulse for a write into ROM space
//  Revision : 1.0 - initial release
// ============================================================================
module rom_bus_ctrl #(
  parameter int LATENCY = 2  // clk edges from address to valid dout, 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        iorq_n,
  output logic [12:0] rom_ad,
  output logic        rom0_ce,
  output logic        rom1_ce,
  output logic        rom_oce,
  output logic        rom_iorq,
  output logic        wait_n,
  output logic        rom_wr_ignored
);

  localparam int             c_cnt_w    = 3;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRIVE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_bank;
  logic                 w_bank_nxt;
  logic [12:0]          w_ad_nxt;
  logic                 w_ce0_nxt;
  logic                 w_ce1_nxt;
  logic                 w_oce_nxt;
  logic                 w_wait_n_nxt;
  logic                 w_wr_ign_nxt;

  logic w_hit;
  logic w_strobe;

  // An active I/O cycle masks the memory decode even if mreq_n is low.
  assign w_hit    = !mreq_n && iorq_n && (addr[15:14] == 2'b00);
  // The read strobe pair that keeps an access alive once started.
  assign w_strobe = !mreq_n && !rd_n;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bank_nxt   = r_bank;
    w_ad_nxt     = rom_ad;
    w_ce0_nxt    = 1'b0;
    w_ce1_nxt    = 1'b0;
    w_oce_nxt    = 1'b0;
    w_wait_n_nxt = 1'b1;
    w_wr_ign_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A read wins over a simultaneous write strobe.
        if (w_hit && !rd_n) begin
          w_state_nxt  = ST_ACCESS;
          w_cnt_nxt    = c_cnt_load;
          w_bank_nxt   = addr[13];
          w_ad_nxt     = addr[12:0];
          w_ce0_nxt    = !addr[13];
          w_ce1_nxt    = addr[13];
          w_oce_nxt    = 1'b1;
          w_wait_n_nxt = 1'b0;
        end else if (w_hit && !wr_n) begin
          w_wr_ign_nxt = 1'b1;
        end
      end

      ST_ACCESS: begin
        // Abort takes priority, including on the final wait cycle.
        if (!w_strobe) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ce0_nxt = !r_bank;
          w_ce1_nxt = r_bank;
          w_oce_nxt = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt  = ST_DRIVE;
            w_wait_n_nxt = 1'b1;
          end else begin
            w_cnt_nxt    = r_cnt - 1'b1;
            w_wait_n_nxt = 1'b0;
          end
        end
      end

      ST_DRIVE: begin
        // Bus is released one clk after the strobe rises.
        if (!w_strobe) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ce0_nxt = !r_bank;
          w_ce1_nxt = r_bank;
          w_oce_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_bank         <= 1'b0;
      rom_ad         <= '0;
      rom0_ce        <= 1'b0;
      rom1_ce        <= 1'b0;
      rom_oce        <= 1'b0;
      rom_iorq       <= 1'b0;
      wait_n         <= 1'b1;
      rom_wr_ignored <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_bank         <= w_bank_nxt;
      rom_ad         <= w_ad_nxt;
      rom0_ce        <= w_ce0_nxt;
      rom1_ce        <= w_ce1_nxt;
      rom_oce        <= w_oce_nxt;
      rom_iorq       <= ~iorq_n;
      wait_n         <= w_wait_n_nxt;
      rom_wr_ignored <= w_wr_ign_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_bus_ctrl
//  Purpose  : Self-checking bench for rom_bus_ctrl. Two instances (LATENCY 2
//             and 3) share the CPU-side inputs. A vector table covers the
//             basic decode, directed sequences cover aborts and mid-access
//             reset, and a randomized run is compared with a cycle-level
//             transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] addr;
  logic        mreq_n, rd_n, wr_n, iorq_n;

  logic [12:0] ad2, ad3;
  logic        ce0_2, ce1_2, oce2, iorq2, wait2, wri2;
  logic        ce0_3, ce1_3, oce3, iorq3, wait3, wri3;

  rom_bus_ctrl #(.LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .addr(addr), .mreq_n(mreq_n), .rd_n(rd_n),
    .wr_n(wr_n), .iorq_n(iorq_n), .rom_ad(ad2), .rom0_ce(ce0_2),
    .rom1_ce(ce1_2), .rom_oce(oce2), .rom_iorq(iorq2), .wait_n(wait2),
    .rom_wr_ignored(wri2)
  );

  rom_bus_ctrl #(.LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .addr(addr), .mreq_n(mreq_n), .rd_n(rd_n),
    .wr_n(wr_n), .iorq_n(iorq_n), .rom_ad(ad3), .rom0_ce(ce0_3),
    .rom1_ce(ce1_3), .rom_oce(oce3), .rom_iorq(iorq3), .wait_n(wait3),
    .rom_wr_ignored(wri3)
  );

  // Observation word: {rom_ad, rom0_ce, rom1_ce, rom_oce, wait_n, wr_ignored, rom_iorq}
  logic [18:0] obs2, obs3;
  assign obs2 = {ad2, ce0_2, ce1_2, oce2, wait2, wri2, iorq2};
  assign obs3 = {ad3, ce0_3, ce1_3, oce3, wait3, wri3, iorq3};

  int checks = 0;
  int errors = 0;

  function automatic logic [18:0] ex(input logic [12:0] ad, input logic c0,
                                     input logic c1, input logic oc,
                                     input logic wt, input logic wi,
                                     input logic io);
    return {ad, c0, c1, oc, wt, wi, io};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got ad=%h ce0/ce1/oce/wait_n/wri/iorq=%b, expected ad=%h ce0/ce1/oce/wait_n/wri/iorq=%b",
               name, $time, act[18:6], act[5:0], exp[18:6], exp[5:0]);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic m, input logic r,
                       input logic w, input logic i);
    @(negedge clk);
    addr = a; mreq_n = m; rd_n = r; wr_n = w; iorq_n = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check both instances immediately, then
  // release it cleanly with the bus idle.
  task automatic reset_mid(input string name);
    #2 reset = 1'b0;
    #1;
    check({name, "_dut2"}, obs2, ex(13'h0, 0, 0, 0, 1, 0, 0));
    check({name, "_dut3"}, obs3, ex(13'h0, 0, 0, 0, 1, 0, 0));
    drive(16'h0000, 1, 1, 1, 1);
    tick();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // Tracks, per instance, whether an access is in progress and how many
  // edges have passed since it was accepted. wait_n is low for the first
  // LATENCY edges of the access; the access ends as soon as the read
  // strobe pair is seen inactive.
  int          lat [2] = '{2, 3};
  bit          m_active [2];
  int          m_age [2];
  logic        m_bank [2];
  logic [12:0] m_ad [2];
  logic        m_wri [2];
  logic        m_iorq [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_age[k] = 0; m_bank[k] = 0;
      m_ad[k] = '0; m_wri[k] = 0; m_iorq[k] = 0;
    end
  endtask

  task automatic model_step();
    bit hit;
    hit = (mreq_n == 1'b0) && (iorq_n == 1'b1) && (addr < 16'h4000);
    for (int k = 0; k < 2; k++) begin
      m_iorq[k] = !iorq_n;
      m_wri[k]  = 1'b0;
      if (!m_active[k]) begin
        if (hit && !rd_n) begin
          m_active[k] = 1; m_age[k] = 0;
          m_bank[k] = addr[13]; m_ad[k] = addr[12:0];
        end else if (hit && !wr_n) begin
          m_wri[k] = 1'b1;
        end
      end else if (mreq_n || rd_n) begin
        m_active[k] = 0;
      end else if (m_age[k] < 1000) begin
        m_age[k]++;
      end
    end
  endtask

  function automatic logic [18:0] model_exp(input int k);
    if (m_active[k])
      return ex(m_ad[k], !m_bank[k], m_bank[k], 1'b1, (m_age[k] >= lat[k]), m_wri[k], m_iorq[k]);
    return ex(m_ad[k], 1'b0, 1'b0, 1'b0, 1'b1, m_wri[k], m_iorq[k]);
  endfunction

  // ---------------- vector table (LATENCY=2 instance) ----------------
  typedef struct packed {
    logic [15:0] a;
    logic        m, r, w, i;
    logic [18:0] e;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic m, input logic r,
                              input logic w, input logic i, input logic [18:0] e);
    vec_t v;
    v.a = a; v.m = m; v.r = r; v.w = w; v.i = i; v.e = e;
    return v;
  endfunction

  vec_t tbl [26];

  initial begin
    // Read 0x0123 held for six cycles, then released.
    tbl[0]  = mk(16'h0123, 0, 0, 1, 1, ex(13'h0123, 1, 0, 1, 0, 0, 0));
    tbl[1]  = mk(16'h0123, 0, 0, 1, 1, ex(13'h0123, 1, 0, 1, 0, 0, 0));
    tbl[2]  = mk(16'h0123, 0, 0, 1, 1, ex(13'h0123, 1, 0, 1, 1, 0, 0));
    tbl[3]  = mk(16'h0123, 0, 0, 1, 1, ex(13'h0123, 1, 0, 1, 1, 0, 0));
    tbl[4]  = mk(16'h0123, 0, 0, 1, 1, ex(13'h0123, 1, 0, 1, 1, 0, 0));
    tbl[5]  = mk(16'h0123, 0, 0, 1, 1, ex(13'h0123, 1, 0, 1, 1, 0, 0));
    tbl[6]  = mk(16'h0123, 1, 1, 1, 1, ex(13'h0123, 0, 0, 0, 1, 0, 0));
    // Top of the ROM selects the upper half.
    tbl[7]  = mk(16'h3FFF, 0, 0, 1, 1, ex(13'h1FFF, 0, 1, 1, 0, 0, 0));
    tbl[8]  = mk(16'h3FFF, 0, 0, 1, 1, ex(13'h1FFF, 0, 1, 1, 0, 0, 0));
    tbl[9]  = mk(16'h3FFF, 0, 0, 1, 1, ex(13'h1FFF, 0, 1, 1, 1, 0, 0));
    tbl[10] = mk(16'h3FFF, 1, 1, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    // First address outside the ROM: nothing happens.
    tbl[11] = mk(16'h4000, 0, 0, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    tbl[12] = mk(16'h4000, 0, 0, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    tbl[13] = mk(16'h4000, 1, 1, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    // Writes: into ROM pulses, outside does not.
    tbl[14] = mk(16'h1000, 0, 1, 0, 1, ex(13'h1FFF, 0, 0, 0, 1, 1, 0));
    tbl[15] = mk(16'h1000, 1, 1, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    tbl[16] = mk(16'h8000, 0, 1, 0, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    tbl[17] = mk(16'h8000, 1, 1, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    // I/O cycle only raises rom_iorq.
    tbl[18] = mk(16'h00FE, 1, 1, 1, 0, ex(13'h1FFF, 0, 0, 0, 1, 0, 1));
    tbl[19] = mk(16'h00FE, 1, 1, 1, 1, ex(13'h1FFF, 0, 0, 0, 1, 0, 0));
    // Read and write together count as a read.
    tbl[20] = mk(16'h0500, 0, 0, 0, 1, ex(13'h0500, 1, 0, 1, 0, 0, 0));
    tbl[21] = mk(16'h0500, 0, 0, 0, 1, ex(13'h0500, 1, 0, 1, 0, 0, 0));
    tbl[22] = mk(16'h0500, 0, 0, 0, 1, ex(13'h0500, 1, 0, 1, 1, 0, 0));
    tbl[23] = mk(16'h0500, 1, 1, 1, 1, ex(13'h0500, 0, 0, 0, 1, 0, 0));
    // mreq_n low during an I/O cycle is not a ROM hit.
    tbl[24] = mk(16'h0010, 0, 0, 1, 0, ex(13'h0500, 0, 0, 0, 1, 0, 1));
    tbl[25] = mk(16'h0010, 1, 1, 1, 1, ex(13'h0500, 0, 0, 0, 1, 0, 0));

    addr = '0; mreq_n = 1; rd_n = 1; wr_n = 1; iorq_n = 1;
    reset = 1'b0;
    tick();
    tick();
    check("reset_dut2", obs2, ex(13'h0, 0, 0, 0, 1, 0, 0));
    check("reset_dut3", obs3, ex(13'h0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    reset = 1'b1;

    for (int n = 0; n < 26; n++) begin
      drive(tbl[n].a, tbl[n].m, tbl[n].r, tbl[n].w, tbl[n].i);
      tick();
      check($sformatf("table_row%0d", n), obs2, tbl[n].e);
    end

    // Abort after one ACCESS cycle, then an immediate read to 0x2000.
    drive(16'h0200, 0, 0, 1, 1); tick();
    check("abort_e0_dut3", obs3, ex(13'h0200, 1, 0, 1, 0, 0, 0));
    drive(16'h0200, 0, 1, 1, 1); tick();
    check("abort_idle_dut3", obs3, ex(13'h0200, 0, 0, 0, 1, 0, 0));
    check("abort_idle_dut2", obs2, ex(13'h0200, 0, 0, 0, 1, 0, 0));
    drive(16'h2000, 0, 0, 1, 1); tick();
    check("reread_e0_dut3", obs3, ex(13'h0000, 0, 1, 1, 0, 0, 0));
    tick(); tick();
    check("reread_e2_dut3", obs3, ex(13'h0000, 0, 1, 1, 0, 0, 0));
    tick();
    check("reread_e3_dut3", obs3, ex(13'h0000, 0, 1, 1, 1, 0, 0));
    drive(16'h2000, 1, 1, 1, 1); tick();
    check("reread_rel_dut3", obs3, ex(13'h0000, 0, 0, 0, 1, 0, 0));

    // Abort sampled on the last wait cycle of the LATENCY=2 instance.
    drive(16'h0400, 0, 0, 1, 1); tick(); tick();
    check("lastabort_e1_dut2", obs2, ex(13'h0400, 1, 0, 1, 0, 0, 0));
    drive(16'h0400, 0, 1, 1, 1); tick();
    check("lastabort_idle_dut2", obs2, ex(13'h0400, 0, 0, 0, 1, 0, 0));
    drive(16'h0000, 1, 1, 1, 1); tick();

    // Reset during ACCESS, then a normal read.
    drive(16'h0123, 0, 0, 1, 1); tick();
    check("rstacc_pre_dut2", obs2, ex(13'h0123, 1, 0, 1, 0, 0, 0));
    reset_mid("rst_in_access");
    drive(16'h2345, 0, 0, 1, 1); tick();
    check("postrst1_e0_dut2", obs2, ex(13'h0345, 0, 1, 1, 0, 0, 0));
    tick(); tick();
    check("postrst1_e2_dut2", obs2, ex(13'h0345, 0, 1, 1, 1, 0, 0));
    drive(16'h2345, 1, 1, 1, 1); tick();
    check("postrst1_rel_dut2", obs2, ex(13'h0345, 0, 0, 0, 1, 0, 0));

    // Reset during DRIVE, then a normal read.
    drive(16'h0077, 0, 0, 1, 1); tick(); tick(); tick();
    check("rstdrv_pre_dut2", obs2, ex(13'h0077, 1, 0, 1, 1, 0, 0));
    reset_mid("rst_in_drive");
    drive(16'h1ABC, 0, 0, 1, 1); tick();
    check("postrst2_e0_dut2", obs2, ex(13'h1ABC, 1, 0, 1, 0, 0, 0));
    tick(); tick();
    check("postrst2_e2_dut2", obs2, ex(13'h1ABC, 1, 0, 1, 1, 0, 0));
    drive(16'h1ABC, 1, 1, 1, 1); tick();
    check("postrst2_rel_dut2", obs2, ex(13'h1ABC, 0, 0, 0, 1, 0, 0));

    // Randomized run against the transaction model, both latencies.
    drive(16'h0000, 1, 1, 1, 1);
    reset = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int s = 0; s < 300; s++) begin
      logic [15:0] a;
      logic        m, r, w, i;
      int          hold;
      a    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF));
      m    = ($urandom_range(0, 4) == 0);
      r    = ($urandom_range(0, 9) >= 7);
      w    = ($urandom_range(0, 3) != 0);
      i    = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(1, 6);
      for (int c = 0; c < hold; c++) begin
        drive(a, m, r, w, i);
        model_step();
        tick();
        check("random_dut2", obs2, model_exp(0));
        check("random_dut3", obs3, model_exp(1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
